// File: rtl/spi_slave_frame_ctrl.sv
// SPI slave front-end: deserialises one command frame per SS_n assertion, pulses rx_valid,
// and shifts RAM read data out on MISO. Optional feature macro: SPI_SLAVE_ABORT_CNT_EN.
module spi_slave_frame_ctrl #(
  parameter int unsigned CMD_W  = 2,
  parameter int unsigned DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    SS_n,
  input  logic                    MOSI,
  output logic                    MISO,
  output logic [CMD_W+DATA_W-1:0] rx_data,
  output logic                    rx_valid,
  input  logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_valid,
`ifdef SPI_SLAVE_ABORT_CNT_EN
  output logic [7:0]              abort_cnt,
`endif
  output logic                    busy
);

  localparam int unsigned FRAME_W = CMD_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
  localparam int unsigned OUT_W   = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] FrameCnt = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] LastBit  = CNT_W'(FRAME_W - 1);
  localparam logic [OUT_W-1:0] OutLast  = OUT_W'(DATA_W);

  typedef enum logic [2:0] {
    StIdle,
    StChkCmd,
    StWrite,
    StReadAdd,
    StReadData,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0]    out_q, out_d;
  logic [OUT_W-1:0]     out_cnt_q, out_cnt_d;
  logic                 miso_q, miso_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      out_q      <= '0;
      out_cnt_q  <= '0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rd_pend_q  <= rd_pend_d;
      out_q      <= out_d;
      out_cnt_q  <= out_cnt_d;
      miso_q     <= miso_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rd_pend_d  = rd_pend_q;
    out_d      = out_q;
    out_cnt_d  = out_cnt_q;
    miso_d     = 1'b0;

    if (SS_n) begin
      // Deselect aborts from any state; completed-frame side effects already happened.
      state_d   = StIdle;
      bit_cnt_d = '0;
      out_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d   = StChkCmd;
          bit_cnt_d = '0;
        end
        StChkCmd: begin
          shift_d   = {{(FRAME_W - 1){1'b0}}, MOSI};
          bit_cnt_d = CNT_W'(1);
          if (!MOSI)          state_d = StWrite;
          else if (rd_pend_q) state_d = StReadData;
          else                state_d = StReadAdd;
        end
        StWrite, StReadAdd, StReadData: begin
          if (bit_cnt_q < FrameCnt) begin
            shift_d   = {shift_q[FRAME_W-2:0], MOSI};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LastBit) begin
              rx_data_d  = shift_d;
              rx_valid_d = 1'b1;
              if (state_q == StWrite) begin
                state_d = StDone;
              end else if (state_q == StReadAdd) begin
                rd_pend_d = 1'b1;
                state_d   = StDone;
              end else begin
                rd_pend_d = 1'b0;
              end
            end
          end else if (state_q == StReadData) begin
            // out_cnt_q == 0 means still waiting for the RAM to present read data.
            if (out_cnt_q == '0) begin
              if (tx_valid) begin
                miso_d    = tx_data[DATA_W-1];
                out_d     = tx_data << 1;
                out_cnt_d = OUT_W'(1);
              end
            end else if (out_cnt_q < OutLast) begin
              miso_d    = out_q[DATA_W-1];
              out_d     = out_q << 1;
              out_cnt_d = out_cnt_q + 1'b1;
            end else begin
              out_cnt_d = '0;
              state_d   = StDone;
            end
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != StIdle);

`ifdef SPI_SLAVE_ABORT_CNT_EN
  logic [7:0] abort_cnt_q, abort_cnt_d;
  logic       mid_frame;

  always_comb begin
    mid_frame   = ((bit_cnt_q != '0) && (bit_cnt_q < FrameCnt)) || (out_cnt_q != '0);
    abort_cnt_d = abort_cnt_q;
    if (SS_n && mid_frame && (abort_cnt_q != 8'hFF)) begin
      abort_cnt_d = abort_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) abort_cnt_q <= '0;
    else     abort_cnt_q <= abort_cnt_d;
  end

  assign abort_cnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_spi_slave_frame_ctrl.sv
// Self-checking bench for spi_slave_frame_ctrl (CMD_W=2, DATA_W=8): session-level reference
// model with per-cycle comparison, directed literal checks, then randomized sessions.
module tb_spi_slave_frame_ctrl;

  localparam int CMD_W  = 2;
  localparam int DATA_W = 8;
  localparam int FW     = CMD_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst, ss_n, mosi, miso, rx_valid, tx_valid, busy;
  logic [FW-1:0]     rx_data;
  logic [DATA_W-1:0] tx_data;
`ifdef SPI_SLAVE_ABORT_CNT_EN
  logic [7:0]        abort_cnt;
`endif

  spi_slave_frame_ctrl #(
    .CMD_W (CMD_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (ss_n),
    .MOSI     (mosi),
    .MISO     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
`ifdef SPI_SLAVE_ABORT_CNT_EN
    .abort_cnt(abort_cnt),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          busy;
    logic          valid;
    logic          miso;
    logic [FW-1:0] rx;
    logic [7:0]    ab;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          cur;
  int            n_chk  = 0;
  int            n_fail = 0;
  logic [FW-1:0] rx_m;
  bit            rd_pend_m;
  logic [7:0]    ab_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // One expectation per clock edge, checked shortly after that edge.
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("busy", {31'd0, busy}, {31'd0, cur.busy});
      chk("rx_valid", {31'd0, rx_valid}, {31'd0, cur.valid});
      chk("miso", {31'd0, miso}, {31'd0, cur.miso});
      chk("rx_data", {22'd0, rx_data}, {22'd0, cur.rx});
`ifdef SPI_SLAVE_ABORT_CNT_EN
      chk("abort_cnt", {24'd0, abort_cnt}, {24'd0, cur.ab});
`endif
    end
  end

  task automatic step(input bit r, input bit s, input bit m, input bit tv,
                      input logic [7:0] td, input exp_t e);
    rst = r; ss_n = s; mosi = m; tx_valid = tv; tx_data = td;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_edges(input int n);
    exp_t ex;
    for (int g = 0; g < n; g++) begin
      ex.busy = 1'b0; ex.valid = 1'b0; ex.miso = 1'b0; ex.rx = rx_m; ex.ab = ab_m;
      step(1'b0, 1'b1, 1'($urandom), 1'($urandom), 8'($urandom), ex);
    end
  endtask

  // Session: SS_n low for len edges (edge 0 is the idle edge, edges 1..FW carry the frame),
  // then a terminating edge with SS_n high or rst. tx_valid first asserted at edge e_rel.
  task automatic session(input logic [FW-1:0] frame, input int len, input int e_rel,
                         input logic [7:0] txd, input bit end_rst,
                         output int n_valid, output logic [7:0] miso_bits);
    bit         rd_data, complete, r, s, m, tv, mb;
    logic [7:0] td;
    exp_t       ex;
    rd_data   = frame[FW-1] && rd_pend_m;
    complete  = (len >= FW + 1);
    n_valid   = 0;
    miso_bits = '0;
    for (int j = 0; j <= len; j++) begin
      m  = (j >= 1 && j <= FW) ? frame[FW-j] : 1'($urandom);
      tv = 1'($urandom);
      td = 8'($urandom);
      if (rd_data && complete && j >= FW + 1 && j < e_rel) tv = 1'b0;
      if (rd_data && complete && j == e_rel) begin
        tv = 1'b1;
        td = txd;
      end
      r = 1'b0;
      s = 1'b0;
      if (j == len) begin
        if (end_rst) begin
          r = 1'b1;
          s = 1'($urandom);
        end else begin
          s = 1'b1;
        end
      end
      if (j == len && end_rst) begin
        rx_m = '0; rd_pend_m = 1'b0; ab_m = '0;
        ex.busy = 1'b0; ex.valid = 1'b0; ex.miso = 1'b0;
      end else if (j == len) begin
        if ((len >= 2 && len <= FW) ||
            (rd_data && complete && len - 1 >= e_rel && len - 1 <= e_rel + 7)) begin
          if (ab_m != 8'hFF) ab_m = ab_m + 8'd1;
        end
        ex.busy = 1'b0; ex.valid = 1'b0; ex.miso = 1'b0;
      end else begin
        if (j == FW) begin
          rx_m = frame;
          if (frame[FW-1]) rd_pend_m = !rd_data;
        end
        mb = (rd_data && complete && j >= e_rel && j <= e_rel + 7) ? txd[7-(j-e_rel)] : 1'b0;
        ex.busy = 1'b1; ex.valid = (j == FW); ex.miso = mb;
      end
      ex.rx = rx_m;
      ex.ab = ab_m;
      step(r, s, m, tv, td, ex);
      if (rx_valid === 1'b1) n_valid++;
      if (j < len && j >= e_rel && j <= e_rel + 7) miso_bits[7-(j-e_rel)] = miso;
    end
  endtask

  initial begin
    int         nv;
    logic [7:0] mb;
    int         len, e_rel;
    rx_m = '0; rd_pend_m = 1'b0; ab_m = '0;
    cur = '0;
    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, '0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset rx_data", {22'd0, rx_data}, 32'd0);
    idle_edges(1);

    // Write with 14 MOSI bits under one select: only the first 10 form the frame.
    session(10'b00_1010_0101, 15, 99, 8'h00, 1'b0, nv, mb);
    chk("write rx_data", {22'd0, rx_data}, 32'h0A5);
    chk("write single pulse", nv, 32'd1);
    idle_edges(1);

    session(10'h213, 12, 99, 8'h00, 1'b0, nv, mb);
    chk("read addr rx_data", {22'd0, rx_data}, 32'h213);
    idle_edges(1);

    session(10'h300, 23, 13, 8'hC3, 1'b0, nv, mb);
    chk("read data miso C3", {24'd0, mb}, 32'hC3);
    chk("read data pulse", nv, 32'd1);
    idle_edges(1);

    // Pending cleared, so this read is an address frame and returns nothing.
    session(10'h300, 23, 13, 8'h5A, 1'b0, nv, mb);
    chk("pend cleared miso", {24'd0, mb}, 32'h00);
    idle_edges(1);

    session(10'h155, 7, 99, 8'h00, 1'b0, nv, mb);
    chk("abort no pulse", nv, 32'd0);
    chk("abort rx_data kept", {22'd0, rx_data}, 32'h300);
`ifdef SPI_SLAVE_ABORT_CNT_EN
    chk("abort count", {24'd0, abort_cnt}, 32'd1);
`endif
    idle_edges(1);

    session(10'h3FF, 15, 12, 8'hFF, 1'b1, nv, mb);
    chk("rst miso", {31'd0, miso}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst rx_data", {22'd0, rx_data}, 32'd0);
    session(10'h200, 23, 13, 8'hA5, 1'b0, nv, mb);
    chk("rst clears pend", {24'd0, mb}, 32'h00);
    idle_edges(1);

    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 9) < 7) len = 11 + int'($urandom_range(0, 14));
      else                          len = int'($urandom_range(1, 10));
      e_rel = 11 + int'($urandom_range(0, 3));
      session(10'($urandom), len, e_rel, 8'($urandom), ($urandom_range(0, 24) == 0), nv, mb);
      idle_edges(int'($urandom_range(0, 2)));
    end

    chk("expectations drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
